mem_access_stage: RTL

Parametrised memory-access pipeline stage between EX and WB of the RV32IM pipeline. Replaces the single-cycle pass-through data-memory path with a request/acknowledge bus to a variable-latency data memory. Adds byte-enable generation, store-lane replication, load extraction with sign/zero extension, a pipeline stall output, and a registered MEM/WB boundary.

---
 rtl/mem_access_stage.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between EX and WB: request/acknowledge data-memory bus,
// byte enables, store lane replication, load extraction. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5,
    parameter int BE_W = XLEN / 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EX_VALID,
    input  logic [2:0]      EX_FUNC3,
    input  logic            EX_WRITE_ENABLE,
    input  logic            EX_DATA_MEM_SELECT,
    input  logic            EX_MEM_WRITE,
    input  logic            EX_MEM_READ,
    input  logic [XLEN-1:0] EX_ALU_RESULT,
    input  logic [XLEN-1:0] EX_READ_DATA2,
    input  logic [RD_W-1:0] EX_RD,
    output logic            MEM_STALL,
    output logic            DM_REQ,
    output logic            DM_WE,
    output logic [XLEN-1:0] DM_ADDR,
    output logic [XLEN-1:0] DM_WDATA,
    output logic [BE_W-1:0] DM_BE,
    input  logic            DM_ACK,
    input  logic [XLEN-1:0] DM_RDATA,
    output logic            WB_VALID,
    output logic            WB_WRITE_ENABLE,
    output logic            WB_DATA_MEM_SELECT,
    output logic [XLEN-1:0] WB_ALU_RESULT,
    output logic [XLEN-1:0] WB_LOAD_DATA,
    output logic [RD_W-1:0] WB_RD
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            WB_MISALIGN
`endif
);

    localparam int         OFF_W   = $clog2(BE_W);
    localparam logic [1:0] LG_FULL = 2'(OFF_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Access size as log2(bytes); unknown codes fall back to a full-width access.
    function automatic logic [1:0] size_lg(input logic [2:0] f3);
        logic [1:0] lg;
        case (f3)
            3'b000, 3'b100: lg = 2'd0;
            3'b001, 3'b101: lg = 2'd1;
            3'b010:         lg = 2'd2;
            3'b110:         lg = (XLEN == 64) ? 2'd2 : LG_FULL;
            3'b011:         lg = (XLEN == 64) ? 2'd3 : LG_FULL;
            default:        lg = LG_FULL;
        endcase
        return lg;
    endfunction

    function automatic logic [OFF_W-1:0] align_off(input logic [OFF_W-1:0] off, input logic [1:0] lg);
        logic [OFF_W-1:0] mask;
        mask = {OFF_W{1'b1}} << lg;
        return off & mask;
    endfunction

    function automatic logic [BE_W-1:0] be_gen(input logic [OFF_W-1:0] off_al, input logic [1:0] lg);
        logic [BE_W-1:0] ones;
        ones = ~({BE_W{1'b1}} << (1 << lg));
        return ones << off_al;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] data, input logic [1:0] lg);
        logic [XLEN-1:0] r;
        r = data;
        case (lg)
            2'd0: for (int i = 0; i < BE_W; i++) r[i*8 +: 8] = data[7:0];
            2'd1: for (int i = 0; i < BE_W / 2; i++) r[i*16 +: 16] = data[15:0];
            2'd2: for (int i = 0; i < XLEN / 32; i++) r[i*32 +: 32] = data[31:0];
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [OFF_W-1:0] off_al,
                                                     input logic [1:0] lg, input logic uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off_al, 3'b000};
        case (lg)
            2'd0:    r = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'd1:    r = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'd2:    r = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t           state_r, state_nx_s;
    logic             ex_mem_s, accept_s, mem_stall_s, wb_load_ex_s, wb_load_ack_s, trap_s;
    logic [1:0]       ex_lg_s;
    logic [OFF_W-1:0] ex_off_s, ex_off_al_s;

    logic             dm_we_r;
    logic [XLEN-1:0]  dm_addr_r, dm_wdata_r, req_alu_r;
    logic [BE_W-1:0]  dm_be_r;
    logic [OFF_W-1:0] req_off_r;
    logic [1:0]       req_lg_r;
    logic             req_uns_r, req_we_r, req_dms_r;
    logic [RD_W-1:0]  req_rd_r;

    logic             wb_valid_r, wb_we_r, wb_dms_r;
    logic [XLEN-1:0]  wb_alu_r, wb_load_r;
    logic [RD_W-1:0]  wb_rd_r;

    assign ex_mem_s    = EX_VALID & (EX_MEM_READ | EX_MEM_WRITE);
    assign ex_lg_s     = size_lg(EX_FUNC3);
    assign ex_off_s    = EX_ALU_RESULT[OFF_W-1:0];
    assign ex_off_al_s = align_off(ex_off_s, ex_lg_s);

    // Next-state and stall/capture decode.
    always_comb begin
        state_nx_s    = state_r;
        accept_s      = 1'b0;
        mem_stall_s   = 1'b0;
        wb_load_ex_s  = 1'b0;
        wb_load_ack_s = 1'b0;
        trap_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ex_mem_s) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (ex_off_s != ex_off_al_s) begin
                        trap_s = 1'b1;
                    end else begin
                        accept_s    = 1'b1;
                        mem_stall_s = 1'b1;
                        state_nx_s  = ST_REQ;
                    end
`else
                    accept_s    = 1'b1;
                    mem_stall_s = 1'b1;
                    state_nx_s  = ST_REQ;
`endif
                end else begin
                    wb_load_ex_s = 1'b1;
                end
            end
            ST_REQ: begin
                if (DM_ACK) begin
                    wb_load_ack_s = 1'b1;
                    state_nx_s    = ST_IDLE;
                end else begin
                    mem_stall_s = 1'b1;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state_r <= ST_IDLE;
        else      state_r <= state_nx_s;
    end

    // Request registers: bus fields are precomputed at acceptance so they stay stable until ack.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dm_we_r    <= 1'b0;
            dm_addr_r  <= '0;
            dm_wdata_r <= '0;
            dm_be_r    <= '0;
            req_off_r  <= '0;
            req_lg_r   <= 2'd0;
            req_uns_r  <= 1'b0;
            req_we_r   <= 1'b0;
            req_dms_r  <= 1'b0;
            req_alu_r  <= '0;
            req_rd_r   <= '0;
        end else if (accept_s) begin
            dm_we_r    <= EX_MEM_WRITE;
            dm_addr_r  <= {EX_ALU_RESULT[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            dm_wdata_r <= replicate(EX_READ_DATA2, ex_lg_s);
            dm_be_r    <= be_gen(ex_off_al_s, ex_lg_s);
            req_off_r  <= ex_off_al_s;
            req_lg_r   <= ex_lg_s;
            req_uns_r  <= EX_FUNC3[2];
            req_we_r   <= EX_WRITE_ENABLE;
            req_dms_r  <= EX_DATA_MEM_SELECT;
            req_alu_r  <= EX_ALU_RESULT;
            req_rd_r   <= EX_RD;
        end
    end

    // MEM/WB boundary registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wb_valid_r <= 1'b0;
            wb_we_r    <= 1'b0;
            wb_dms_r   <= 1'b0;
            wb_alu_r   <= '0;
            wb_load_r  <= '0;
            wb_rd_r    <= '0;
        end else if (wb_load_ack_s) begin
            wb_valid_r <= 1'b1;
            wb_we_r    <= req_we_r;
            wb_dms_r   <= req_dms_r;
            wb_alu_r   <= req_alu_r;
            wb_load_r  <= dm_we_r ? '0 : load_extract(DM_RDATA, req_off_r, req_lg_r, req_uns_r);
            wb_rd_r    <= req_rd_r;
        end else if (trap_s) begin
            wb_valid_r <= 1'b1;
            wb_we_r    <= 1'b0;
            wb_dms_r   <= EX_DATA_MEM_SELECT;
            wb_alu_r   <= EX_ALU_RESULT;
            wb_load_r  <= '0;
            wb_rd_r    <= EX_RD;
        end else if (wb_load_ex_s) begin
            wb_valid_r <= EX_VALID;
            wb_we_r    <= EX_WRITE_ENABLE;
            wb_dms_r   <= EX_DATA_MEM_SELECT;
            wb_alu_r   <= EX_ALU_RESULT;
            wb_load_r  <= '0;
            wb_rd_r    <= EX_RD;
        end else begin
            wb_valid_r <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic wb_misalign_r;

    // Misalignment flag travels with the trapped instruction only.
    always_ff @(posedge CLK) begin
        if (!RST) wb_misalign_r <= 1'b0;
        else      wb_misalign_r <= trap_s;
    end

    assign WB_MISALIGN = wb_misalign_r;
`endif

    assign MEM_STALL          = mem_stall_s;
    assign DM_REQ             = (state_r == ST_REQ);
    assign DM_WE              = dm_we_r;
    assign DM_ADDR            = dm_addr_r;
    assign DM_WDATA           = dm_wdata_r;
    assign DM_BE              = dm_be_r;
    assign WB_VALID           = wb_valid_r;
    assign WB_WRITE_ENABLE    = wb_we_r;
    assign WB_DATA_MEM_SELECT = wb_dms_r;
    assign WB_ALU_RESULT      = wb_alu_r;
    assign WB_LOAD_DATA       = wb_load_r;
    assign WB_RD              = wb_rd_r;

endmodule
